// File: rtl/mem_to_reqrsp_if.sv
// mem_to_reqrsp_if: core memory port plus reqrsp request/response structs for the mem_to_reqrsp bridge.
interface mem_to_reqrsp_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic                    write;
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] strb;
        logic [2:0]              size;
        logic [3:0]              amo;
    } q_t;
    typedef struct packed {
        logic q_valid;
        q_t   q;
        logic p_ready;
    } req_t;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  error;
    } p_t;
    typedef struct packed {
        logic q_ready;
        logic p_valid;
        p_t   p;
    } resp_t;
    logic                    mem_req;
    logic                    mem_gnt;
    logic                    mem_we;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_rvalid;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_err;
    req_t                    req_o;
    resp_t                   resp_i;
    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_i,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err, req_o
    );
    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_i,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err, req_o
    );
endinterface

// File: rtl/mem_to_reqrsp.sv
// mem_to_reqrsp: core req/gnt memory port to reqrsp initiator bridge with outstanding limit and spurious-response flag.
// Define MEM2REQRSP_RSP_BUF_EN to register the response path (one extra cycle of response latency).
module mem_to_reqrsp #(
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    mem_to_reqrsp_if.slave bus,
    output logic           spurious_o
);
    localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [2:0]      SIZE    = 3'($clog2(DATA_WIDTH / 8));
    logic [CW-1:0] r_cnt;
    logic          r_spurious;
    logic          w_q_valid;
    logic          w_q_hs;
    logic          w_p_hs;
    logic          w_dec;
    assign w_q_valid   = bus.mem_req & (r_cnt < MAX_CNT);
    assign w_q_hs      = w_q_valid & bus.resp_i.q_ready;
    assign w_p_hs      = bus.resp_i.p_valid;
    // A response with nothing outstanding never retires a slot.
    assign w_dec       = w_p_hs & (r_cnt != '0);
    assign bus.mem_gnt = w_q_hs;
    assign spurious_o  = r_spurious;
    always_comb begin
        bus.req_o         = '0;
        bus.req_o.q_valid = w_q_valid;
        bus.req_o.q.addr  = bus.mem_addr;
        bus.req_o.q.write = bus.mem_we;
        bus.req_o.q.data  = bus.mem_wdata;
        bus.req_o.q.strb  = bus.mem_be;
        bus.req_o.q.size  = SIZE;
        bus.req_o.q.amo   = 4'd0;
        bus.req_o.p_ready = 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_cnt      <= (w_q_hs && !w_dec) ? r_cnt + 1'b1 :
                          (!w_q_hs && w_dec) ? r_cnt - 1'b1 : r_cnt;
            r_spurious <= r_spurious | (w_p_hs & (r_cnt == '0));
        end
    end
`ifdef MEM2REQRSP_RSP_BUF_EN
    logic                  r_rvalid;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= bus.resp_i.p_valid;
            if (bus.resp_i.p_valid) begin
                r_rdata <= bus.resp_i.p.data;
                r_err   <= bus.resp_i.p.error;
            end
        end
    end
    assign bus.mem_rvalid = r_rvalid;
    assign bus.mem_rdata  = r_rdata;
    assign bus.mem_err    = r_err;
`else
    assign bus.mem_rvalid = bus.resp_i.p_valid;
    assign bus.mem_rdata  = bus.resp_i.p.data;
    assign bus.mem_err    = bus.resp_i.p.error;
`endif
endmodule

// File: tb/tb_mem_to_reqrsp.sv
// tb_mem_to_reqrsp: directed self-checking bench for mem_to_reqrsp (honours MEM2REQRSP_RSP_BUF_EN latency).
module tb_mem_to_reqrsp;
    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    logic spurious;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    mem_to_reqrsp_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus ();
    mem_to_reqrsp #(.DATA_WIDTH(64), .MAX_OUTSTANDING(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .bus        (bus),
        .spurious_o (spurious)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic rsp_chk(input string tag, input logic [63:0] d, input logic e, input logic chk_data);
        chk({tag, ".rvalid"}, bus.mem_rvalid, 1);
        if (chk_data) chk({tag, ".rdata"}, bus.mem_rdata, d);
        chk({tag, ".err"}, bus.mem_err, e);
    endtask
    // Presents one response for one clock edge and checks it where the core sees it.
    task automatic respond(input string tag, input logic [63:0] d, input logic e, input logic chk_data);
        bus.resp_i.p_valid = 1'b1;
        bus.resp_i.p.data  = d;
        bus.resp_i.p.error = e;
`ifdef MEM2REQRSP_RSP_BUF_EN
        cyc();
        rsp_chk(tag, d, e, chk_data);
`else
        #1;
        rsp_chk(tag, d, e, chk_data);
        cyc();
`endif
        bus.resp_i.p_valid = 1'b0;
    endtask
    initial begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.resp_i    = '0;
        cyc();
        cyc();
        chk("rst.gnt", bus.mem_gnt, 0);
        chk("rst.rvalid", bus.mem_rvalid, 0);
        chk("rst.rdata", bus.mem_rdata, 0);
        chk("rst.err", bus.mem_err, 0);
        chk("rst.spur", spurious, 0);
        chk("rst.qvalid", bus.req_o.q_valid, 0);
        chk("rst.cnt", dut.r_cnt, 0);
        rst_ni = 1'b1;
        chk("pready", bus.req_o.p_ready, 1);
        // single read
        bus.resp_i.q_ready = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h100;
        bus.mem_be   = 8'hFF;
        #1;
        chk("rd.gnt", bus.mem_gnt, 1);
        chk("rd.qvalid", bus.req_o.q_valid, 1);
        chk("rd.addr", bus.req_o.q.addr, 64'h100);
        chk("rd.write", bus.req_o.q.write, 0);
        cyc();
        bus.mem_req = 1'b0;
        chk("rd.cnt1", dut.r_cnt, 1);
        cyc();
        respond("rd", 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1);
        #1;
        chk("rd.cnt0", dut.r_cnt, 0);
        // full-width write
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h40;
        bus.mem_be    = 8'hFF;
        bus.mem_wdata = 64'h1122334455667788;
        #1;
        chk("wr.gnt", bus.mem_gnt, 1);
        chk("wr.write", bus.req_o.q.write, 1);
        chk("wr.strb", bus.req_o.q.strb, 64'hFF);
        chk("wr.size", bus.req_o.q.size, 3);
        chk("wr.amo", bus.req_o.q.amo, 0);
        chk("wr.data", bus.req_o.q.data, 64'h1122334455667788);
        cyc();
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        respond("wr", 64'h0, 1'b0, 1'b0);
        cyc();
        chk("wr.once", bus.mem_rvalid, 0);
        chk("wr.cnt0", dut.r_cnt, 0);
        // outstanding limit
        bus.mem_addr = 32'h200;
        bus.mem_req  = 1'b1;
        #1;
        chk("lim.g1", bus.mem_gnt, 1);
        cyc();
        chk("lim.g2", bus.mem_gnt, 1);
        cyc();
        chk("lim.qvalid", bus.req_o.q_valid, 0);
        chk("lim.gnt", bus.mem_gnt, 0);
        chk("lim.cnt", dut.r_cnt, 2);
        cyc();
        chk("lim.hold", bus.mem_gnt, 0);
        respond("lim", 64'h1, 1'b0, 1'b1);
        #1;
        chk("lim.regrant", bus.mem_gnt, 1);
        cyc();
        chk("lim.one", bus.mem_gnt, 0);
        bus.mem_req = 1'b0;
        respond("d1", 64'h2, 1'b0, 1'b1);
        respond("d2", 64'h3, 1'b0, 1'b1);
        #1;
        chk("lim.drain", dut.r_cnt, 0);
        // simultaneous q and p handshakes at cnt=1
        bus.mem_req = 1'b1;
        #1;
        cyc();
        chk("sim.cnt1", dut.r_cnt, 1);
        respond("sim", 64'h44, 1'b0, 1'b1);
        bus.mem_req = 1'b0;
        chk("sim.hold", dut.r_cnt, 1);
        respond("sim2", 64'h55, 1'b0, 1'b1);
        #1;
        chk("sim.cnt0", dut.r_cnt, 0);
        // backpressure then error response
        bus.resp_i.q_ready = 1'b0;
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.gnt", bus.mem_gnt, 0);
            chk("bp.qvalid", bus.req_o.q_valid, 1);
            cyc();
        end
        bus.resp_i.q_ready = 1'b1;
        #1;
        chk("bp.gnt1", bus.mem_gnt, 1);
        cyc();
        bus.mem_req = 1'b0;
        respond("err", 64'hBAD, 1'b1, 1'b1);
        #1;
        chk("err.cnt0", dut.r_cnt, 0);
        // spurious response, then reset mid-operation
        chk("sp.pre", spurious, 0);
        respond("sp", 64'hA5A5A5A5_5A5A5A5A, 1'b0, 1'b1);
        chk("sp.flag", spurious, 1);
        chk("sp.cnt", dut.r_cnt, 0);
        bus.mem_req = 1'b1;
        cyc();
        bus.mem_req = 1'b0;
        chk("sp.sticky", spurious, 1);
        chk("sp.cnt1", dut.r_cnt, 1);
        rst_ni = 1'b0;
        bus.resp_i.p.data  = '0;
        bus.resp_i.p.error = 1'b0;
        cyc();
        rst_ni = 1'b1;
        chk("rst2.spur", spurious, 0);
        chk("rst2.cnt", dut.r_cnt, 0);
        chk("rst2.rvalid", bus.mem_rvalid, 0);
        chk("rst2.rdata", bus.mem_rdata, 0);
        respond("late", 64'h77, 1'b0, 1'b1);
        chk("late.spur", spurious, 1);
        chk("late.cnt", dut.r_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
